// File: rtl/fft_sample_buffer_if.sv
// Purpose: sample-stream, frame-read and overflow signals of the FFT ping-pong buffer.
// Latency: none; this interface only groups wires.
// Backpressure: none here; the buffer drops samples and flags overflow when both banks are full.
// Modports: master = capture/FFT side (drives in_*, rd_*, ovf_clr); slave = buffer.
interface fft_sample_buffer_if #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 2048
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] fill_level;
    logic              frame_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;
    logic              ovf_flag;
    logic              ovf_clr;
    logic [15:0]       ovf_count;

    modport master (
        output in_valid, in_data, rd_en, rd_addr, rd_done, ovf_clr,
        input  fill_level, frame_valid, rd_data, ovf_flag, ovf_count
    );

    modport slave (
        input  in_valid, in_data, rd_en, rd_addr, rd_done, ovf_clr,
        output fill_level, frame_valid, rd_data, ovf_flag, ovf_count
    );
endinterface

// File: rtl/fft_sample_buffer.sv
// Purpose: two-bank ping-pong buffer; capture fills one bank while the FFT reads a full frame from the other.
// Latency: read data 1 cycle after rd_en; frame_valid 1 cycle after the last write of a frame or after rd_done.
// Backpressure: none upstream; samples arriving while the write bank is still full are dropped and flagged.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport): in_valid/in_data, fill_level,
//        frame_valid, rd_en/rd_addr/rd_data, rd_done, ovf_flag/ovf_clr/ovf_count.
// Option: define FFT_BUF_OVF_CNT_EN to build the saturating 16-bit dropped-sample counter;
//         otherwise ovf_count reads as zero.
module fft_sample_buffer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_sample_buffer_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    // Both banks share one array; the bank index is the address MSB.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic              wbank;
    logic              rbank;
    logic [ADDR_W-1:0] wptr;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              rbank_nxt;
    logic              frame_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              ovf_flag_q;

    logic              wr_acc;
    logic              drop;
    logic              last_wr;
    logic              release_bank;

    assign wr_acc       = bus.in_valid && !full[wbank];
    assign drop         = bus.in_valid &&  full[wbank];
    assign last_wr      = wr_acc && (wptr == ADDR_W'(DEPTH - 1));
    // frame_valid mirrors full[rbank], so a release can never target the bank being written.
    assign release_bank = bus.rd_done && frame_valid_q;
    assign rbank_nxt    = rbank ^ release_bank;

    always_comb begin
        full_nxt = full;
        if (release_bank) full_nxt[rbank] = 1'b0;
        if (last_wr)      full_nxt[wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wptr          <= '0;
            full          <= 2'b00;
            frame_valid_q <= 1'b0;
            rd_data_q     <= '0;
            ovf_flag_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (last_wr) begin
                    wptr  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wptr  <= wptr + 1'b1;
                end
            end
            full  <= full_nxt;
            rbank <= rbank_nxt;
            // Evaluated on next-state values so a completed frame is visible one cycle after its last write.
            frame_valid_q <= full_nxt[rbank_nxt];
            if (bus.rd_en) rd_data_q <= mem[{rbank, bus.rd_addr}];
            // A drop in the same cycle as a clear wins.
            if (drop)             ovf_flag_q <= 1'b1;
            else if (bus.ovf_clr) ovf_flag_q <= 1'b0;
        end
    end

    // Storage is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[{wbank, wptr}] <= bus.in_data;
    end

`ifdef FFT_BUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt_q <= 16'd0;
        end else if (drop) begin
            if (bus.ovf_clr)                ovf_cnt_q <= 16'd1;
            else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end else if (bus.ovf_clr) begin
            ovf_cnt_q <= 16'd0;
        end
    end

    assign bus.ovf_count = ovf_cnt_q;
`else
    assign bus.ovf_count = 16'd0;
`endif

    assign bus.fill_level  = wptr;
    assign bus.frame_valid = frame_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.ovf_flag    = ovf_flag_q;
endmodule
